mcca_issue_ctrl: RTL and testbench



---
 rtl/mcca_pkg.sv | 26 ++
 rtl/mcca_phase_cnt.sv | 27 ++
 rtl/mcca_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_mcca_issue_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcca_pkg.sv
// Shared types and defaults for the Manchester carry-chain adder issue stage.
package mcca_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRECH,
        EVAL,
        HOLD
    } state_t;

    localparam logic PH_PRECH = 1'b0;
    localparam logic PH_EVAL  = 1'b1;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_PRE_CYCLES  = 1;
    localparam int DEF_EVAL_CYCLES = 2;

    // The counter only ever holds window-1, so clog2 of the longer window is
    // enough; keep at least one bit so a 1-cycle window still synthesizes.
    function automatic int cnt_width(input int pre, input int eval);
        int m;
        m = (pre > eval) ? pre : eval;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mcca_phase_cnt.sv
// Loadable down-counter with zero flag, timing both precharge and evaluate windows.
module mcca_phase_cnt #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mcca_issue_ctrl.sv
// Operand issue, phase sequencing and result capture around the dynamic
// Manchester carry-chain adder, with a behavioural self-check of each result.
module mcca_issue_ctrl
    import mcca_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int PRE_CYCLES  = DEF_PRE_CYCLES,
    parameter int EVAL_CYCLES = DEF_EVAL_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    output logic             add_phase,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             err
);

    localparam int CW = cnt_width(PRE_CYCLES, EVAL_CYCLES);

    state_t          state;
    logic            accept;
    logic            cnt_load;
    logic [CW-1:0]   cnt_val;
    logic            cnt_dec;
    logic            cnt_zero;
    logic [WIDTH:0]  ref_sum;

    assign accept  = in_valid && in_ready;
    assign ref_sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    cnt_val  = CW'(PRE_CYCLES - 1);
                end
            end
            PRECH: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = CW'(EVAL_CYCLES - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            EVAL: begin
                cnt_dec = !cnt_zero;
            end
            default: ;
        endcase
    end

    mcca_phase_cnt #(.CW(CW)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Operands stay frozen from accept until the next accept, so the chain
    // sees stable inputs across precharge and the whole evaluate window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            add_phase <= PH_PRECH;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        add_a     <= in_a;
                        add_b     <= in_b;
                        add_cin   <= in_cin;
                        in_ready  <= 1'b0;
                        add_phase <= PH_PRECH;
                        state     <= PRECH;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                PRECH: begin
                    if (cnt_zero) begin
                        add_phase <= PH_EVAL;
                        state     <= EVAL;
                    end
                end
                EVAL: begin
                    if (cnt_zero) begin
                        out_sum   <= add_sum;
                        out_cout  <= add_cout;
                        out_ovf   <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                                     (add_sum[WIDTH-1] != add_a[WIDTH-1]);
                        out_valid <= 1'b1;
                        add_phase <= PH_PRECH;
                        if (ref_sum != {add_cout, add_sum}) begin
                            err <= 1'b1;
                        end
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcca_issue_ctrl.sv
// Directed bench for mcca_issue_ctrl with a phase-aware adder model that can
// inject a single-bit sum fault.
module tb_mcca_issue_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic             add_phase;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             err;

    logic             corrupt;
    logic [WIDTH:0]   full_sum;

    int checks   = 0;
    int failures = 0;

    mcca_issue_ctrl #(
        .WIDTH       (WIDTH),
        .PRE_CYCLES  (1),
        .EVAL_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_phase (add_phase),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Precharged nodes read as all ones; only the evaluate phase yields a sum.
    always_comb begin
        full_sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        if (add_phase) begin
            add_sum  = full_sum[WIDTH-1:0] ^ {{(WIDTH-1){1'b0}}, corrupt};
            add_cout = full_sum[WIDTH];
        end else begin
            add_sum  = '1;
            add_cout = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        int waited;
        waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("inReadyBeforeIssue", 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("inReadyAfterAccept", 32'(in_ready), 32'd0);
        checkOutput("addA", 32'(add_a), 32'(a));
        checkOutput("addB", 32'(add_b), 32'(b));
        checkOutput("addCin", 32'(add_cin), 32'(cin));
        checkOutput("phasePrech", 32'(add_phase), 32'd0);
    endtask

    task automatic waitResult();
        @(negedge clk);
        checkOutput("phaseEval1", 32'(add_phase), 32'd1);
        @(negedge clk);
        checkOutput("phaseEval2", 32'(add_phase), 32'd1);
        checkOutput("validEarly", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("validOnTime", 32'(out_valid), 32'd1);
        checkOutput("phaseAfterEval", 32'(add_phase), 32'd0);
    endtask

    task automatic checkResult(input logic [WIDTH-1:0] sum, input logic cout, input logic ovf, input logic errExp);
        checkOutput("outSum", 32'(out_sum), 32'(sum));
        checkOutput("outCout", 32'(out_cout), 32'(cout));
        checkOutput("outOvf", 32'(out_ovf), 32'(ovf));
        checkOutput("err", 32'(err), 32'(errExp));
    endtask

    task automatic drainResult();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("validAfterDrain", 32'(out_valid), 32'd0);
        checkOutput("inReadyAfterDrain", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        corrupt   = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rstInReady", 32'(in_ready), 32'd0);
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstPhase", 32'(add_phase), 32'd0);
        checkOutput("rstAddA", 32'(add_a), 32'd0);
        checkOutput("rstOutSum", 32'(out_sum), 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("inReadyAfterReset", 32'(in_ready), 32'd1);

        applyStimulus(16'h1234, 16'h4321, 1'b0);
        waitResult();
        checkResult(16'h5555, 1'b0, 1'b0, 1'b0);
        drainResult();

        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        waitResult();
        checkResult(16'h0000, 1'b1, 1'b0, 1'b0);
        drainResult();

        applyStimulus(16'h7FFF, 16'h0000, 1'b1);
        waitResult();
        checkResult(16'h8000, 1'b0, 1'b1, 1'b0);
        drainResult();

        applyStimulus(16'h00FF, 16'h0F01, 1'b0);
        waitResult();
        in_a     = 16'hAAAA;
        in_b     = 16'h5555;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bpOutSum", 32'(out_sum), 32'h1000);
            checkOutput("bpOutCout", 32'(out_cout), 32'd0);
            checkOutput("bpOutOvf", 32'(out_ovf), 32'd0);
            checkOutput("bpOutValid", 32'(out_valid), 32'd1);
            checkOutput("bpInReady", 32'(in_ready), 32'd0);
            checkOutput("bpAddA", 32'(add_a), 32'h00FF);
        end
        in_valid = 1'b0;
        drainResult();

        corrupt = 1'b1;
        applyStimulus(16'h0002, 16'h0003, 1'b0);
        waitResult();
        checkResult(16'h0004, 1'b0, 1'b0, 1'b1);
        drainResult();
        corrupt = 1'b0;

        applyStimulus(16'h1234, 16'h4321, 1'b0);
        waitResult();
        checkResult(16'h5555, 1'b0, 1'b0, 1'b1);
        drainResult();

        applyStimulus(16'h0100, 16'h0200, 1'b0);
        @(negedge clk);
        checkOutput("midPhaseEval1", 32'(add_phase), 32'd1);
        @(negedge clk);
        checkOutput("midPhaseEval2", 32'(add_phase), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstPhase", 32'(add_phase), 32'd0);
        checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
        checkOutput("midRstInReady", 32'(in_ready), 32'd0);
        checkOutput("midRstErr", 32'(err), 32'd0);
        checkOutput("midRstAddA", 32'(add_a), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("midRstHoldValid", 32'(out_valid), 32'd0);
        checkOutput("midRstHoldReady", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("inReadyAfterMidRst", 32'(in_ready), 32'd1);
        checkOutput("noResultAfterMidRst", 32'(out_valid), 32'd0);

        applyStimulus(16'h0010, 16'h0020, 1'b0);
        waitResult();
        checkResult(16'h0030, 1'b0, 1'b0, 1'b0);
        drainResult();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
